grid_loader: RTL

GRID_LOADER -- requirements
Module: grid_loader

---
 rtl/grid_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/grid_loader.sv
// grid_loader: collects nine 4-bit digits into a 3x3 grid (row-major) and
// presents it to a downstream magic-square checker with a valid/ack handshake.
// Optional duplicate detection is enabled by defining GRID_DUP_CHECK_EN.
module grid_loader #(
  parameter bit CLEAR_ON_ACK = 1'b1
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic       digit_ready,
  input  logic       clear,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [3:0] num5,
  output logic [3:0] num6,
  output logic [3:0] num7,
  output logic [3:0] num8,
  output logic [3:0] num9,
  output logic       grid_valid,
  input  logic       grid_ack,
  output logic [3:0] count,
  output logic       grid_dup
);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] count_reg, count_next;
  logic [3:0] cell_reg [9];
  logic       accept;
  logic       ack_take;

  // Handshake qualifiers; clear always wins over both.
  assign accept   = (state_reg == LOAD) && digit_valid && !clear;
  assign ack_take = (state_reg == FULL) && grid_ack && !clear;

  // Next-state and cell-count logic.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (clear) begin
      state_next = LOAD;
      count_next = 4'd0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (accept) begin
            count_next = count_reg + 4'd1;
            // The ninth digit completes the grid on this same edge.
            if (count_reg == 4'd8) begin
              state_next = FULL;
            end
          end
        end
        FULL: begin
          if (grid_ack) begin
            state_next = LOAD;
            count_next = 4'd0;
          end
        end
        default: begin
          state_next = LOAD;
          count_next = 4'd0;
        end
      endcase
    end
  end

  // State and count registers.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_reg <= LOAD;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // One register per grid cell; a cell loads only when it is the next slot.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      // Cell gi: cleared by reset/clear (and by ack when CLEAR_ON_ACK), loaded on its accept.
      always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
          cell_reg[gi] <= 4'd0;
        end else if (clear) begin
          cell_reg[gi] <= 4'd0;
        end else if (accept && (count_reg == 4'(gi))) begin
          cell_reg[gi] <= digit;
        end else if (ack_take && CLEAR_ON_ACK) begin
          cell_reg[gi] <= 4'd0;
        end
      end
    end
  endgenerate

  assign num1        = cell_reg[0];
  assign num2        = cell_reg[1];
  assign num3        = cell_reg[2];
  assign num4        = cell_reg[3];
  assign num5        = cell_reg[4];
  assign num6        = cell_reg[5];
  assign num7        = cell_reg[6];
  assign num8        = cell_reg[7];
  assign num9        = cell_reg[8];
  assign count       = count_reg;
  assign grid_valid  = (state_reg == FULL);
  // Ready depends on state only, so there is no path from digit_valid.
  assign digit_ready = (state_reg == LOAD);

`ifdef GRID_DUP_CHECK_EN
  logic dup_any;

  // Pairwise comparison of all 36 cell pairs.
  always_comb begin
    dup_any = 1'b0;
    for (int i = 0; i < 9; i++) begin
      for (int j = i + 1; j < 9; j++) begin
        if (cell_reg[i] == cell_reg[j]) begin
          dup_any = 1'b1;
        end
      end
    end
  end

  assign grid_dup = grid_valid && dup_any;
`else
  assign grid_dup = 1'b0;
`endif

endmodule
